// File: rtl/mnist_argmax_collector.sv
// mnist_argmax_collector
//   Consumes the network core's logit stream (one signed logit per in_valid
//   beat, classes 0..NUM_CLASSES-1 in order) and reports the argmax of each
//   frame as a one-cycle class_valid pulse. Re-arms with no dead cycles, so the
//   next frame's beat 0 may follow the previous frame's final beat directly.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset (deassertion synchronised here)
//   in_valid     logit beat qualifier
//   in_data      signed logit
//   sync_clr     synchronous frame abort; a coincident beat starts a new frame
//   class_idx    index of the maximum logit of the last complete frame
//   class_score  value of that maximum logit
//   class_valid  one-cycle pulse marking new class_idx/class_score
//   beat_cnt     logits accepted in the current frame
//   busy         frame partially received (beat_cnt != 0)
module mnist_argmax_collector #(
  parameter int DATA_W      = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              sync_clr,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic              class_valid,
  output logic [IDX_W-1:0]  beat_cnt,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] run_max, max_nxt;
  logic [IDX_W-1:0]  run_idx, idx_nxt;
  logic              fire;
  logic              restart;

  // Reset asserts immediately but is released two clk edges after rst drops,
  // so no flop leaves reset on an edge that races the external deassertion.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_i = rst_sync[1];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // A beat starts a fresh frame either from IDLE or when sync_clr forces it;
  // beat 0 is loaded without comparing against whatever run_max holds.
  assign restart = sync_clr || (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    max_nxt   = run_max;
    idx_nxt   = run_idx;
    fire      = 1'b0;
    if (in_valid) begin
      if (restart) begin
        max_nxt   = in_data;
        idx_nxt   = '0;
        cnt_nxt   = ONE;
        state_nxt = ACCUM;
      end else begin
        // strict '>' keeps the lowest index among equal maxima
        if ($signed(in_data) > $signed(run_max)) begin
          max_nxt = in_data;
          idx_nxt = beat_cnt;
        end
        if (beat_cnt == LAST_BEAT) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          fire      = 1'b1;
        end else begin
          cnt_nxt = beat_cnt + ONE;
        end
      end
    end else if (sync_clr) begin
      cnt_nxt   = '0;
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt    <= '0;
      run_max     <= '0;
      run_idx     <= '0;
      class_idx   <= '0;
      class_score <= '0;
      class_valid <= 1'b0;
    end else begin
      beat_cnt    <= cnt_nxt;
      run_max     <= max_nxt;
      run_idx     <= idx_nxt;
      class_valid <= fire;
      // the final beat's comparison result goes straight to the outputs
      if (fire) begin
        class_idx   <= idx_nxt;
        class_score <= max_nxt;
      end
    end
  end

  assign busy = (beat_cnt != '0);

endmodule

// File: tb/tb_mnist_argmax_collector.sv
// Testbench for mnist_argmax_collector: a driver issues logit beats and feeds
// a frame-level argmax model that pushes expected results into a queue; a
// monitor on the falling edge pops and compares on every class_valid pulse and
// checks beat_cnt/busy/held outputs each cycle.
module tb_mnist_argmax_collector;
  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        sync_clr = 1'b0;
  logic [3:0]  class_idx;
  logic [31:0] class_score;
  logic        class_valid;
  logic [3:0]  beat_cnt;
  logic        busy;

  mnist_argmax_collector #(.DATA_W(32), .NUM_CLASSES(N), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .sync_clr(sync_clr), .class_idx(class_idx), .class_score(class_score),
    .class_valid(class_valid), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int score; int cyc; } exp_t;

  exp_t expq[$];
  int   cur[$];
  int   errors = 0, checks = 0;
  int   ncyc = 0;
  int   held_idx = 0, held_score = 0;
  int   pulse_cnt = 0, last_pulse = 0, prev_pulse = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Frame-level reference: collect logits, take argmax on the NUM_CLASSES-th.
  task automatic model_beat(input int v, input bit clr);
    int best, bi;
    exp_t e;
    if (clr) cur.delete();
    cur.push_back(v);
    if (cur.size() == N) begin
      best = cur[0]; bi = 0;
      for (int i = 1; i < N; i++)
        if (cur[i] > best) begin best = cur[i]; bi = i; end
      e.idx = bi; e.score = best; e.cyc = ncyc + 1;
      expq.push_back(e);
      cur.delete();
    end
  endtask

  task automatic beat(input int v, input bit clr);
    @(negedge clk);
    in_valid = 1'b1; in_data = v; sync_clr = clr;
    @(posedge clk);
    model_beat(v, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0; sync_clr = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic frame(input int f[N], input int maxgap);
    for (int i = 0; i < N; i++) begin
      beat(f[i], 1'b0);
      if (maxgap > 0 && i < N - 1) idle($urandom_range(0, maxgap));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_valid = 1'b0; sync_clr = 1'b0;
    expq.delete(); cur.delete();
    held_idx = 0; held_score = 0;
    @(negedge clk);
    chk("rst_class_valid", class_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_class_score", class_score, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst) begin
      if (class_valid) begin
        pulse_cnt++;
        prev_pulse = last_pulse;
        last_pulse = ncyc;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: class_valid=1 with no frame completed (cycle %0d)", ncyc);
        end else begin
          e = expq.pop_front();
          chk("class_idx", class_idx, e.idx);
          chk("class_score", int'($signed(class_score)), e.score);
          chk("pulse_cycle", ncyc, e.cyc);
          held_idx = e.idx; held_score = e.score;
        end
      end else begin
        chk("held_idx", class_idx, held_idx);
        chk("held_score", int'($signed(class_score)), held_score);
      end
      chk("beat_cnt", beat_cnt, cur.size());
      chk("busy", busy, cur.size() != 0);
    end
  end

  initial begin
    int f[N];
    int p0;
    apply_reset();

    // distinct pattern with a tie at index 4
    frame('{3, -1, 7, 2, 7, 0, -5, 6, 1, 4}, 0);
    idle(3);
    // all negative
    frame('{-10, -9, -8, -20, -3, -4, -100, -7, -6, -5}, 0);
    idle(2);
    // signed extremes with random gaps
    for (int i = 0; i < N; i++) f[i] = (i == 9) ? 32'h7FFFFFFF : 32'h80000000;
    p0 = pulse_cnt;
    frame(f, 5);
    idle(2);
    chk("extreme_pulse_count", pulse_cnt - p0, 1);
    // back-to-back frames, winners 1 then 8
    frame('{0, 9, 1, 2, 3, 4, 5, 6, 7, 8}, 0);
    frame('{1, 2, 3, 4, 5, 6, 7, 8, 50, 9}, 0);
    idle(3);
    chk("b2b_spacing", last_pulse - prev_pulse, 10);
    // abort mid-frame with a coincident beat
    p0 = pulse_cnt;
    for (int i = 0; i < 6; i++) beat(int'($urandom_range(0, 200)) - 100, 1'b0);
    beat(50, 1'b1);
    for (int i = 0; i < 9; i++) beat(10, 1'b0);
    idle(3);
    chk("abort_pulse_count", pulse_cnt - p0, 1);
    // abort on the final beat
    for (int i = 0; i < 9; i++) beat(i, 1'b0);
    beat(-1, 1'b1);
    for (int i = 0; i < 9; i++) beat(-2, 1'b0);
    idle(2);
    // reset between the final beat and its pulse
    p0 = pulse_cnt;
    for (int i = 0; i < N; i++) beat(i * 3, 1'b0);
    #2;
    apply_reset();
    chk("rst_suppressed_pulse", pulse_cnt - p0, 0);
    frame('{5, 4, 3, 2, 1, 0, 60, -1, -2, 60}, 0);
    idle(2);
    // random frames: narrow values for ties, gaps, occasional aborts
    for (int fr = 0; fr < 25; fr++) begin
      for (int i = 0; i < N; i++) begin
        int v;
        v = (fr % 2 == 0) ? int'($urandom_range(0, 7)) - 4 : int'($urandom);
        beat(v, $urandom_range(0, 29) == 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(4);
    chk("pending_pulses", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
